// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states and
// size-derived helpers (byte count, byte-enable base pattern, read mask).
package dmem_responder_pkg;

  localparam logic [1:0] DMEM_SZ_B   = 2'b00;
  localparam logic [1:0] DMEM_SZ_H   = 2'b01;
  localparam logic [1:0] DMEM_SZ_W   = 2'b10;
  localparam logic [1:0] DMEM_SZ_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [2:0] bytes_of(input logic [1:0] sz);
    case (sz)
      DMEM_SZ_B: bytes_of = 3'd1;
      DMEM_SZ_H: bytes_of = 3'd2;
      DMEM_SZ_W: bytes_of = 3'd4;
      default:   bytes_of = 3'd0;
    endcase
  endfunction

  // Byte enables for an access that starts at lane 0.
  function automatic logic [3:0] be_of(input logic [1:0] sz);
    case (sz)
      DMEM_SZ_B: be_of = 4'b0001;
      DMEM_SZ_H: be_of = 4'b0011;
      DMEM_SZ_W: be_of = 4'b1111;
      default:   be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] rd_mask_of(input logic [1:0] sz);
    case (sz)
      DMEM_SZ_B: rd_mask_of = 32'h0000_00FF;
      DMEM_SZ_H: rd_mask_of = 32'h0000_FFFF;
      DMEM_SZ_W: rd_mask_of = 32'hFFFF_FFFF;
      default:   rd_mask_of = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// DEPTH x 32 single-port RAM with per-byte write enables and a registered read port.
// Read-during-write returns the old word.
module dmem_responder_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, performs a byte/half/word access
// (split over two RAM cycles when it crosses a word boundary) and answers with a ready pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_dmem,
  input  logic        write_dmem,
  input  logic [31:0] addr_dmem,
  input  logic [31:0] write_data_dmem,
  input  logic [1:0]  dmem_size,
  output logic [31:0] read_data_dmem,
  output logic        dmem_ready,
  output logic        dmem_busy,
  output logic        dmem_error,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken only in IDLE on a cycle where read_dmem or
  // write_dmem is high; it completes with exactly one dmem_ready pulse, and
  // requests presented while dmem_busy=1 are dropped.

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_wr;
  logic              r_fault;
  logic [31:0]       r_lo;
  logic [31:0]       r_rd_data;
  logic              r_ready;
  logic              r_busy;
  logic              r_error;

  logic              w_req;
  logic              w_fault_in;
  logic              w_cross;
  logic [ADDR_W-1:0] w_word;
  logic [ADDR_W-1:0] w_word_nxt;
  logic [4:0]        w_shift;
  logic [63:0]       w_wr_wide;
  logic [7:0]        w_be_wide;
  logic [31:0]       w_lo;
  logic [31:0]       w_rd_shift;
  logic [31:0]       w_rd_val;

  logic [ADDR_W-1:0] w_ram_addr;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;

  assign w_req      = read_dmem | write_dmem;
  assign w_fault_in = (dmem_size == DMEM_SZ_ILL) || (read_dmem && write_dmem) ||
                      (addr_dmem[31:ADDR_W+2] != '0);

  assign w_cross    = (({1'b0, r_addr[1:0]} + bytes_of(r_size)) > 3'd4);
  assign w_word     = r_addr[ADDR_W+1:2];
  assign w_word_nxt = w_word + ADDR_W'(1);
  assign w_shift    = {r_addr[1:0], 3'b000};
  assign w_wr_wide  = {32'h0, r_wdata} << w_shift;
  assign w_be_wide  = {4'h0, be_of(r_size)} << r_addr[1:0];

  // For a crossing read the low word was latched during ACC2; the RAM output in RESP is then word w+1.
  assign w_lo       = w_cross ? r_lo : w_ram_rdata;
  assign w_rd_shift = 32'({w_ram_rdata, w_lo} >> w_shift);
  assign w_rd_val   = w_rd_shift & rd_mask_of(r_size);

  always_comb begin
    w_state_nxt = r_state;
    w_ram_addr  = w_word;
    w_ram_be    = 4'b0000;
    w_ram_wdata = w_wr_wide[31:0];
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_state_nxt = w_fault_in ? ST_RESP : ST_ACC1;
      end
      ST_ACC1: begin
        if (r_wr && !rst) w_ram_be = w_be_wide[3:0];
        w_state_nxt = w_cross ? ST_ACC2 : ST_RESP;
      end
      ST_ACC2: begin
        w_ram_addr  = w_word_nxt;
        w_ram_wdata = w_wr_wide[63:32];
        if (r_wr && !rst) w_ram_be = w_be_wide[7:4];
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_rd_data <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      if (r_state == ST_IDLE && w_req) begin
        r_addr  <= addr_dmem[ADDR_W+1:0];
        r_wdata <= write_data_dmem;
        r_size  <= dmem_size;
        r_wr    <= write_dmem;
        r_fault <= w_fault_in;
        r_busy  <= 1'b1;
      end
      if (r_state == ST_ACC2) r_lo <= w_ram_rdata;
      if (r_state == ST_RESP) begin
        r_ready   <= 1'b1;
        r_busy    <= 1'b0;
        r_error   <= r_fault;
        r_rd_data <= (r_fault || r_wr) ? 32'h0 : w_rd_val;
      end
    end
  end

  dmem_responder_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign read_data_dmem = r_rd_data;
  assign dmem_ready     = r_ready;
  assign dmem_busy      = r_busy;
  assign dmem_error     = r_error;
  assign dbg_state      = r_state;

endmodule
